// File: rtl/pixel_scan_reader.sv
// Raster timing generator that walks one image tile of the pixel memory in
// raster order and drives grayscale video with sync and data-enable.
module pixel_scan_reader #(
  parameter int ADDR_W    = 19,
  parameter int BASE_ADDR = 0,
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int NUM_TILES = 4,
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cuadrante,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        pixel_out,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);

  localparam logic [31:0] H_ACT_U  = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT_U  = 32'(V_ACTIVE);
  localparam logic [31:0] IMG_W_U  = 32'(IMG_W);
  localparam logic [31:0] IMG_H_U  = 32'(IMG_H);
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] TILES_U  = 32'(NUM_TILES);

  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TILE_SIZE = ADDR_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] ROW_SIZE  = ADDR_W'(IMG_W);

  // Raster position and frame-wide tile
  logic [DIV_W-1:0]  div;
  logic [H_W-1:0]    h;
  logic [V_W-1:0]    v;
  logic [3:0]        tile;
  logic [ADDR_W-1:0] addr_hold;

  // Classification of the position processed on the current tick
  logic              tick;
  logic              first;
  logic              active;
  logic              in_img;
  logic              hs_n;
  logic              vs_n;
  logic [3:0]        tile_sel;
  logic [3:0]        cur_tile;
  logic [ADDR_W-1:0] addr_now;
  logic [31:0]       h_ext;
  logic [31:0]       v_ext;

  // Classification carried across the one-clk read latency
  logic ld;
  logic s_active;
  logic s_img;
  logic s_hs;
  logic s_vs;
  logic s_first;

  assign h_ext = 32'(h);
  assign v_ext = 32'(v);

  // NOTE: every signal is assigned on every path through this block, so no
  // latch can be inferred; keep it that way when adding terms.
  always_comb begin
    tick     = (div == DIV_LAST);
    first    = (h == '0) && (v == '0);
    active   = (h_ext < H_ACT_U) && (v_ext < V_ACT_U);
    in_img   = active && (h_ext < IMG_W_U) && (v_ext < IMG_H_U);
    hs_n     = !((h_ext >= HS_START) && (h_ext < HS_END));
    vs_n     = !((v_ext >= VS_START) && (v_ext < VS_END));
    tile_sel = (32'(cuadrante) < TILES_U) ? cuadrante : 4'd0;
    // Pixel (0,0) reads with the tile being latched on this very tick.
    cur_tile = first ? tile_sel : tile;
    addr_now = BASE_A + ADDR_W'(cur_tile) * TILE_SIZE
             + ADDR_W'(v) * ROW_SIZE + ADDR_W'(h);
  end

  // The strobe lives in the tick clk itself so the RAM samples it on the tick
  // edge; gating with reset keeps it low while the block is held in reset.
  assign rd_en   = reset && tick && in_img;
  assign rd_addr = rd_en ? addr_now : addr_hold;

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      tile        <= '0;
      addr_hold   <= '0;
      ld          <= 1'b0;
      s_active    <= 1'b0;
      s_img       <= 1'b0;
      s_hs        <= 1'b1;
      s_vs        <= 1'b1;
      s_first     <= 1'b0;
      pixel_out   <= '0;
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + DIV_W'(1);
      ld          <= tick;
      frame_start <= ld && s_first;

      if (tick) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + V_W'(1);
        end else begin
          h <= h + H_W'(1);
        end
        if (first) tile <= tile_sel;
        s_active <= active;
        s_img    <= in_img;
        s_hs     <= hs_n;
        s_vs     <= vs_n;
        s_first  <= first;
      end

      if (rd_en) addr_hold <= addr_now;

      // rd_data for the previous tick is valid now; load the whole output set.
      if (ld) begin
        de        <= s_active;
        hsync     <= s_hs;
        vsync     <= s_vs;
        pixel_out <= s_img ? rd_data : 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_scan_reader.sv
// Scoreboard bench for pixel_scan_reader on a small raster (H 8/2/2/2,
// V 4/1/1/1, image 4x2, CLK_DIV 2, base 0x100).
module tb_pixel_scan_reader;

  localparam int ADDR_W   = 19;
  localparam int CLK_DIV  = 2;
  localparam int H_ACT    = 8;
  localparam int V_ACT    = 4;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 2;
  localparam int HS_CLKS  = 4;    // 2 sync pixels * 2 clks
  localparam int VS_CLKS  = 28;   // one 14-pixel line * 2 clks
  localparam int LINE_CLK = 16;   // 8 active pixels * 2 clks
  localparam int HGAP_CLK = 12;   // h=8..13
  localparam int VGAP_CLK = 96;   // h=8..13 of v=3 plus lines v=4..6
  localparam int FRAME_CK = 196;  // 14 * 7 * 2
  localparam int READS_PF = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [3:0]        cuadrante = 4'd0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data = 8'h00;
  logic [7:0]        pixel_out;
  logic              de;
  logic              hsync;
  logic              vsync;
  logic              frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ADDR_W-1:0] rd_q[$];
  logic [7:0]        pix_q[$];

  pixel_scan_reader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(32'h100), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .NUM_TILES(4), .CLK_DIV(CLK_DIV),
    .H_ACTIVE(H_ACT), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(V_ACT), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .reset(reset), .cuadrante(cuadrante),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pixel_out(pixel_out), .de(de), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous memory: low address byte one clk after the strobe, junk otherwise.
  always @(posedge clk) rd_data <= rd_en ? rd_addr[7:0] : 8'hA5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name, input string why);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s at %0t", name, why, $time);
  endtask

  // One frame of expectations from the hand-computed first read address of
  // the selected tile: rows of the image are 4 addresses apart.
  task automatic push_frame(input logic [ADDR_W-1:0] first_addr);
    logic [ADDR_W-1:0] a;
    for (int vv = 0; vv < V_ACT; vv++) begin
      for (int hh = 0; hh < H_ACT; hh++) begin
        if (vv < IMG_H && hh < IMG_W) begin
          a = first_addr + ADDR_W'(vv * IMG_W + hh);
          rd_q.push_back(a);
          pix_q.push_back(a[7:0]);
        end else begin
          pix_q.push_back(8'h00);
        end
      end
    end
  endtask

  task automatic wait_fs(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) seen = 1'b1;
    end
    if (!seen) report_fail(name, "frame_start not seen within 400 clks");
  endtask

  // Monitor state
  int                sub_cnt, hs_low, vs_low, de_high, de_low, clk_since_fs, reads_since_fs;
  logic              have_fs, de_low_valid, prev_fs, prev_rd;
  logic [ADDR_W-1:0] last_addr;

  always @(negedge clk) begin
    if (!reset) begin
      check("reset_outputs", {19'd0, hsync, vsync, de, rd_en, frame_start, pixel_out},
            {19'd0, 13'h1800});
      check("reset_rd_addr", 32'(rd_addr), 32'd0);
      sub_cnt = 0; hs_low = 0; vs_low = 0; de_high = 0; de_low = 0;
      clk_since_fs = 0; reads_since_fs = 0;
      have_fs = 1'b0; de_low_valid = 1'b0; prev_fs = 1'b0; prev_rd = 1'b0;
      last_addr = '0;
    end else begin
      clk_since_fs++;

      if (rd_en) begin
        check("rd_spacing", 32'(prev_rd), 32'd0);
        if (rd_q.size() == 0) report_fail("rd_addr", "read with no expected address");
        else check("rd_addr", 32'(rd_addr), 32'(rd_q.pop_front()));
        last_addr = rd_addr;
        reads_since_fs++;
      end else begin
        check("rd_addr_hold", 32'(rd_addr), 32'(last_addr));
      end

      if (frame_start) begin
        check("fs_with_de", 32'(de), 32'd1);
        check("fs_one_clk", 32'(prev_fs), 32'd0);
        if (have_fs) begin
          check("frame_period", clk_since_fs, FRAME_CK);
          check("reads_per_frame", reads_since_fs, READS_PF);
        end
        have_fs = 1'b1;
        clk_since_fs = 0;
        reads_since_fs = 0;
      end

      if (de) begin
        if (de_low != 0 && de_low_valid)
          check("de_gap", de_low, frame_start ? VGAP_CLK : HGAP_CLK);
        de_low = 0;
        de_high++;
        if (pix_q.size() == 0) begin
          report_fail("pixel", "active pixel with no expected value");
        end else begin
          check("pixel", 32'(pixel_out), 32'(pix_q[0]));
          if (frame_start) check("fs_pixel_start", sub_cnt, 0);
          sub_cnt++;
          if (sub_cnt == CLK_DIV) begin
            void'(pix_q.pop_front());
            sub_cnt = 0;
          end
        end
      end else begin
        check("pixel_blank", 32'(pixel_out), 32'd0);
        if (de_high != 0) begin
          check("de_width", de_high, LINE_CLK);
          de_low_valid = 1'b1;
        end
        de_high = 0;
        de_low++;
      end

      if (!hsync) hs_low++;
      else if (hs_low != 0) begin
        check("hsync_width", hs_low, HS_CLKS);
        hs_low = 0;
      end

      if (!vsync) vs_low++;
      else if (vs_low != 0) begin
        check("vsync_width", vs_low, VS_CLKS);
        vs_low = 0;
      end

      prev_fs = frame_start;
      prev_rd = rd_en;
    end
  end

  initial begin
    // Reset held for five clks with the clock running; monitor checks values.
    reset = 1'b0;
    cuadrante = 4'd0;
    push_frame(19'h100);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;

    // Frame 0: tile 0. Select tile 2 for frame 1.
    wait_fs("fs_frame0");
    @(posedge clk); #1 cuadrante = 4'd2;
    push_frame(19'h110);

    // Frame 1: tile 2 (line 1 at 0x114..0x117). Back to tile 0.
    wait_fs("fs_frame1");
    @(posedge clk); #1 cuadrante = 4'd0;
    push_frame(19'h100);

    // Frame 2: switch to tile 3 around v=1; takes effect next frame only.
    wait_fs("fs_frame2");
    repeat (30) @(posedge clk);
    #1 cuadrante = 4'd3;
    push_frame(19'h118);

    // Frame 3: tile 3. Out-of-range selector falls back to tile 0.
    wait_fs("fs_frame3");
    @(posedge clk); #1 cuadrante = 4'd9;
    push_frame(19'h100);

    // Frame 4: reset pulse near v=2, h=3; outstanding expectations dropped.
    wait_fs("fs_frame4");
    repeat (60) @(posedge clk);
    #1 reset = 1'b0;
    rd_q.delete();
    pix_q.delete();
    push_frame(19'h100);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Frame after reset restarts at 0x100 with frame_start; then tile 1.
    wait_fs("fs_after_reset");
    @(posedge clk); #1 cuadrante = 4'd1;
    push_frame(19'h108);

    wait_fs("fs_tile1");
    for (int i = 0; i < 300 && (pix_q.size() != 0 || rd_q.size() != 0); i++)
      @(negedge clk);
    check("pixels_drained", pix_q.size(), 0);
    check("reads_drained", rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
